// File: rtl/per2apb_bridge.sv
// per2apb_bridge: peripheral req/gnt/r_valid master port to APB3 master bridge.
// One outstanding transaction; all APB and response outputs are registered.
// Optional feature macro: PER2APB_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES
// wait cycles, answering with an error and 32'hDEAD_BEEF).
module per2apb_bridge #(
  parameter int unsigned PER_ADDR_WIDTH = 15,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] APB_BASE_ADDR = APB_ADDR_WIDTH'(32'h1A10_0000),
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  output logic                      per_slave_gnt_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_t;

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_d;
  logic [31:0]               pwdata_d, r_rdata_d;
  logic                      pwrite_d, psel_d, penable_d;
  logic                      r_valid_d, r_opc_d;

`ifdef PER2APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Grant only in IDLE and never while reset is held.
  assign per_slave_gnt_o = per_slave_req_i && (state_q == IDLE) && !rst_i;

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q             <= IDLE;
      PADDR               <= '0;
      PWDATA              <= '0;
      PWRITE              <= 1'b0;
      PSEL                <= 1'b0;
      PENABLE             <= 1'b0;
      per_slave_r_valid_o <= 1'b0;
      per_slave_r_opc_o   <= 1'b0;
      per_slave_r_rdata_o <= '0;
`ifdef PER2APB_TIMEOUT_EN
      cnt_q               <= '0;
`endif
    end else begin
      state_q             <= state_d;
      PADDR               <= paddr_d;
      PWDATA              <= pwdata_d;
      PWRITE              <= pwrite_d;
      PSEL                <= psel_d;
      PENABLE             <= penable_d;
      per_slave_r_valid_o <= r_valid_d;
      per_slave_r_opc_o   <= r_opc_d;
      per_slave_r_rdata_o <= r_rdata_d;
`ifdef PER2APB_TIMEOUT_EN
      cnt_q               <= cnt_d;
`endif
    end
  end

  // Next-state and next-output logic; r_valid is a one-cycle pulse set on entry to RESP/ERR.
  always_comb begin
    state_d   = state_q;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    pwrite_d  = PWRITE;
    psel_d    = PSEL;
    penable_d = PENABLE;
    r_valid_d = 1'b0;
    r_opc_d   = per_slave_r_opc_o;
    r_rdata_d = per_slave_r_rdata_o;
`ifdef PER2APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (per_slave_gnt_o) begin
          // Word-align by masking the two low address bits.
          paddr_d  = APB_BASE_ADDR
                   | APB_ADDR_WIDTH'(per_slave_add_i & ~PER_ADDR_WIDTH'(3));
          pwrite_d = per_slave_we_i;
          pwdata_d = per_slave_wdata_i;
          if (per_slave_we_i && (per_slave_be_i != 4'hF)) begin
            // Partial writes are not expressible on APB3: reject without a bus cycle.
            state_d   = ERR;
            r_valid_d = 1'b1;
            r_opc_d   = 1'b1;
            r_rdata_d = 32'h0;
          end else begin
            psel_d  = 1'b1;
            state_d = SETUP;
`ifdef PER2APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          r_rdata_d = PWRITE ? 32'h0 : PRDATA;
          r_opc_d   = PSLVERR;
          r_valid_d = 1'b1;
          state_d   = RESP;
        end
`ifdef PER2APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          r_rdata_d = 32'hDEAD_BEEF;
          r_opc_d   = 1'b1;
          r_valid_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_per2apb_bridge.sv
// Directed self-checking bench for per2apb_bridge.
module tb_per2apb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [14:0] add = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = 4'hF;
  logic        gnt, r_valid, r_opc;
  logic [31:0] r_rdata;
  logic [31:0] paddr, pwdata, prdata = '0;
  logic        pwrite, psel, penable;
  logic        pready = 1'b0, pslverr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  per2apb_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .per_slave_req_i(req), .per_slave_add_i(add), .per_slave_we_i(we),
    .per_slave_wdata_i(wdata), .per_slave_be_i(be),
    .per_slave_gnt_o(gnt), .per_slave_r_valid_o(r_valid),
    .per_slave_r_opc_o(r_opc), .per_slave_r_rdata_o(r_rdata),
    .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel),
    .PENABLE(penable), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request at the start of a cycle and let gnt settle.
  task automatic drive_req(input logic [14:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] b);
    req = 1'b1; add = a; we = w; wdata = d; be = b;
    #1;
  endtask

  initial begin
    // Reset state, including gnt suppression while reset is high.
    step();
    req = 1'b1;
    step();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_rvalid", 64'(r_valid), 64'd0);
    check("rst_ropc", 64'(r_opc), 64'd0);
    check("rst_rdata", 64'(r_rdata), 64'd0);
    req = 1'b0;
    rst = 1'b0;
    step();

    // Read, zero wait states.
    pready = 1'b1; prdata = 32'hCAFE_0001;
    drive_req(15'h0010, 1'b0, 32'h0, 4'hF);
    check("rd_gnt_c0", 64'(gnt), 64'd1);
    step(); req = 1'b0;
    check("rd_setup_psel", 64'({psel, penable}), 64'b10);
    check("rd_paddr", 64'(paddr), 64'h1A10_0010);
    check("rd_pwrite", 64'(pwrite), 64'd0);
    step();
    check("rd_access", 64'({psel, penable}), 64'b11);
    check("rd_rvalid_c2", 64'(r_valid), 64'd0);
    step();
    check("rd_rvalid_c3", 64'(r_valid), 64'd1);
    check("rd_rdata", 64'(r_rdata), 64'hCAFE_0001);
    check("rd_ropc", 64'(r_opc), 64'd0);
    check("rd_idle_bus", 64'({psel, penable}), 64'b00);
    step();
    check("rd_rvalid_c4", 64'(r_valid), 64'd0);
    check("rd_rdata_hold", 64'(r_rdata), 64'hCAFE_0001);

    // Write with 3 wait states.
    pready = 1'b0; prdata = 32'hFFFF_FFFF;
    drive_req(15'h0104, 1'b1, 32'h1234_5678, 4'hF);
    check("wr_gnt", 64'(gnt), 64'd1);
    step(); req = 1'b0;
    check("wr_paddr", 64'(paddr), 64'h1A10_0104);
    for (int c = 2; c <= 5; c++) begin
      step();
      if (c == 5) pready = 1'b1;
      check($sformatf("wr_access_c%0d", c), 64'({psel, penable, pwrite}), 64'b111);
      check($sformatf("wr_pwdata_c%0d", c), 64'(pwdata), 64'h1234_5678);
      check($sformatf("wr_rvalid_c%0d", c), 64'(r_valid), 64'd0);
    end
    step();
    check("wr_rvalid_c6", 64'(r_valid), 64'd1);
    check("wr_rdata", 64'(r_rdata), 64'd0);
    check("wr_ropc", 64'(r_opc), 64'd0);
    step();

    // PSLVERR read, then back-to-back unaligned read issued during RESP.
    pslverr = 1'b1; prdata = 32'h5555_AAAA;
    drive_req(15'h0008, 1'b0, 32'h0, 4'hF);
    check("err_gnt", 64'(gnt), 64'd1);
    step(); req = 1'b0;
    step();
    step();
    check("err_rvalid", 64'(r_valid), 64'd1);
    check("err_ropc", 64'(r_opc), 64'd1);
    drive_req(15'h0013, 1'b0, 32'h0, 4'hF);
    check("b2b_gnt_in_resp", 64'(gnt), 64'd0);
    step();
    pslverr = 1'b0; prdata = 32'h0BAD_F00D;
    #1;
    check("b2b_gnt_idle", 64'(gnt), 64'd1);
    step(); req = 1'b0;
    check("unaligned_paddr", 64'(paddr), 64'h1A10_0010);
    step();
    step();
    check("b2b_rvalid", 64'(r_valid), 64'd1);
    check("b2b_rdata", 64'(r_rdata), 64'h0BAD_F00D);
    check("b2b_ropc", 64'(r_opc), 64'd0);
    step();

    // Partial write: no APB cycle, error one cycle after gnt.
    drive_req(15'h0020, 1'b1, 32'hA5A5_A5A5, 4'h3);
    check("pw_gnt", 64'(gnt), 64'd1);
    step(); req = 1'b0;
    check("pw_rvalid", 64'(r_valid), 64'd1);
    check("pw_ropc", 64'(r_opc), 64'd1);
    check("pw_rdata", 64'(r_rdata), 64'd0);
    check("pw_no_psel", 64'({psel, penable}), 64'b00);
    step();
    check("pw_rvalid_end", 64'(r_valid), 64'd0);
    check("pw_no_psel2", 64'(psel), 64'd0);

    // Reset during ACCESS aborts silently.
    pready = 1'b0;
    drive_req(15'h0040, 1'b0, 32'h0, 4'hF);
    step(); req = 1'b0;
    step();
    check("rstmid_access", 64'({psel, penable}), 64'b11);
    rst = 1'b1;
    step();
    check("rstmid_bus", 64'({psel, penable}), 64'b00);
    check("rstmid_rvalid", 64'(r_valid), 64'd0);
    rst = 1'b0; pready = 1'b1;
    step();
    check("rstmid_rvalid2", 64'(r_valid), 64'd0);
    step();
    check("rstmid_rvalid3", 64'(r_valid), 64'd0);
    check("rstmid_idle_psel", 64'(psel), 64'd0);

    // PREADY stuck low: timeout abort if enabled, otherwise indefinite wait.
    pready = 1'b0;
    drive_req(15'h0080, 1'b0, 32'h0, 4'hF);
    step(); req = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      step();
      check($sformatf("to_access_c%0d", c), 64'({psel, penable, r_valid}), 64'b110);
    end
    step();
`ifdef PER2APB_TIMEOUT_EN
    check("to_rvalid", 64'(r_valid), 64'd1);
    check("to_ropc", 64'(r_opc), 64'd1);
    check("to_rdata", 64'(r_rdata), 64'hDEAD_BEEF);
    check("to_bus", 64'({psel, penable}), 64'b00);
`else
    check("nto_wait", 64'({psel, penable, r_valid}), 64'b110);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
